// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_if
//  Description : Processor dmem bus between the core and the data-memory
//                responder. It carries the word address, write data, write
//                enable and registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;

    modport master (
        output address_dmem,
        output data,
        output wren,
        input  q_dmem
    );

    modport slave (
        input  address_dmem,
        input  data,
        input  wren,
        output q_dmem
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Word-addressed synchronous data RAM (1-cycle read latency)
//                plus an MMIO window holding the LED register, a free-running
//                cycle counter and a sticky fault register.
//                Optional macro DMEM_WRITE_FORWARD_EN: when defined, a write to
//                RAM or LED returns the new data on the same access instead of
//                the old contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          LED_WIDTH  = 16
) (
    input  wire logic                 clock,
    input  wire logic                 reset,
    dmem_responder_if.slave           bus,
    output logic [LED_WIDTH-1:0]      leds,
    output logic                      fault
);

    // Number of RAM words, kept one bit wider so ADDR_WIDTH=32 still works.
    localparam logic [32:0] c_ram_limit = 33'd1 << ADDR_WIDTH;
    localparam logic [31:0] c_mmio_span = 32'd16;
    localparam logic [31:0] c_off_led   = 32'd0;
    localparam logic [31:0] c_off_cycle = 32'd1;
    localparam logic [31:0] c_off_fault = 32'd2;

`ifdef DMEM_WRITE_FORWARD_EN
    localparam logic c_fwd = 1'b1;
`else
    localparam logic c_fwd = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Storage and registers
    // ------------------------------------------------------------------
    logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [31:0]           r_ram_q;
    logic                  r_sel_ram;
    logic [31:0]           r_mmio_q;
    logic [LED_WIDTH-1:0]  r_leds;
    logic [31:0]           r_cycle;
    logic [1:0]            r_fault;
    logic                  r_fault_any;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                  w_ram_hit;
    logic                  w_in_mmio;
    logic [31:0]           w_mmio_off;
    logic                  w_is_led;
    logic                  w_is_cycle;
    logic                  w_is_fault;
    logic                  w_oor;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic                  w_ram_we;
    logic [LED_WIDTH-1:0]  w_led_rd;
    logic [31:0]           w_mmio_rd;
    logic [1:0]            w_fault_nxt;
    logic [31:0]           w_cycle_nxt;

    assign w_ram_hit  = ({1'b0, bus.address_dmem} < c_ram_limit);
    assign w_mmio_off = bus.address_dmem - MMIO_BASE;
    // RAM takes priority should the window ever overlap it.
    assign w_in_mmio  = !w_ram_hit && (w_mmio_off < c_mmio_span);
    assign w_is_led   = w_in_mmio && (w_mmio_off == c_off_led);
    assign w_is_cycle = w_in_mmio && (w_mmio_off == c_off_cycle);
    assign w_is_fault = w_in_mmio && (w_mmio_off == c_off_fault);
    assign w_oor      = !w_ram_hit && !w_in_mmio;
    assign w_ram_idx  = bus.address_dmem[ADDR_WIDTH-1:0];
    assign w_ram_we   = bus.wren && w_ram_hit;

    // LED read value: old register, or the incoming data when forwarding.
    assign w_led_rd = (c_fwd && bus.wren && w_is_led) ? bus.data[LED_WIDTH-1:0] : r_leds;

    // A CYCLE write clears the counter and beats the increment.
    assign w_cycle_nxt = (bus.wren && w_is_cycle) ? 32'd0 : (r_cycle + 32'd1);

    // MMIO read mux; reserved offsets read as zero.
    always_comb begin
        w_mmio_rd = 32'd0;
        if (w_is_led) begin
            w_mmio_rd[LED_WIDTH-1:0] = w_led_rd;
        end else if (w_is_cycle) begin
            w_mmio_rd = r_cycle;
        end else if (w_is_fault) begin
            w_mmio_rd[1:0] = r_fault;
        end
    end

    // Sticky fault bits; only writes record bit0, only idle-write cycles bit1.
    always_comb begin
        w_fault_nxt = r_fault;
        if (bus.wren && w_is_fault) begin
            w_fault_nxt = 2'b00;
        end else if (w_oor) begin
            if (bus.wren) begin
                w_fault_nxt[0] = 1'b1;
            end else begin
                w_fault_nxt[1] = 1'b1;
            end
        end
    end

    // RAM array and its read register; reset only blocks writes, never clears contents.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ram_q <= 32'd0;
        end else begin
            if (w_ram_we) begin
                r_mem[w_ram_idx] <= bus.data;
            end
            if (c_fwd && w_ram_we) begin
                r_ram_q <= bus.data;
            end else begin
                r_ram_q <= r_mem[w_ram_idx];
            end
        end
    end

    // MMIO state, read-path selection and registered fault summary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sel_ram   <= 1'b0;
            r_mmio_q    <= 32'd0;
            r_leds      <= '0;
            r_cycle     <= 32'd0;
            r_fault     <= 2'b00;
            r_fault_any <= 1'b0;
        end else begin
            r_sel_ram   <= w_ram_hit;
            r_mmio_q    <= w_mmio_rd;
            r_cycle     <= w_cycle_nxt;
            r_fault     <= w_fault_nxt;
            r_fault_any <= |w_fault_nxt;
            if (bus.wren && w_is_led) begin
                r_leds <= bus.data[LED_WIDTH-1:0];
            end
        end
    end

    assign bus.q_dmem = r_sel_ram ? r_ram_q : r_mmio_q;
    assign leds       = r_leds;
    assign fault      = r_fault_any;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. A behavioural model
//                of the memory map predicts q_dmem, leds and fault each cycle;
//                directed sequences add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic [31:0] c_base = 32'hFFFF_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] leds;
    logic        fault;

    dmem_responder_if bus ();

    dmem_responder #(
        .ADDR_WIDTH (12),
        .MMIO_BASE  (c_base),
        .LED_WIDTH  (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .leds  (leds),
        .fault (fault)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model of the memory map
    // ------------------------------------------------------------------
    logic [31:0] m_mem [4096];
    bit          m_ok  [4096];
    logic [15:0] m_leds  = 16'd0;
    logic [31:0] m_cycle = 32'd0;
    logic [1:0]  m_fault = 2'd0;
    logic [31:0] exp_q   = 32'd0;
    bit          exp_ok  = 1'b0;
    bit          started = 1'b0;
`ifdef DMEM_WRITE_FORWARD_EN
    localparam bit c_fwd = 1'b1;
`else
    localparam bit c_fwd = 1'b0;
`endif

    always @(posedge clock) begin
        logic [31:0] a, d, off;
        logic        w;
        a = bus.address_dmem;
        d = bus.data;
        w = bus.wren;
        off = a - c_base;
        started = 1'b1;
        if (!reset) begin
            exp_q = 0; exp_ok = 1;
            m_leds = 0; m_cycle = 0; m_fault = 0;
        end else begin
            // read value from the state before this edge
            exp_ok = 1;
            if (a < 32'd4096) begin
                if (w && c_fwd) exp_q = d;
                else begin exp_q = m_mem[a[11:0]]; exp_ok = m_ok[a[11:0]]; end
            end else if (off < 16) begin
                case (off)
                    0: exp_q = {16'd0, (w && c_fwd) ? d[15:0] : m_leds};
                    1: exp_q = m_cycle;
                    2: exp_q = {30'd0, m_fault};
                    default: exp_q = 0;
                endcase
            end else begin
                exp_q = 0;
            end
            // state updates
            if (w && off == 1) m_cycle = 0; else m_cycle = m_cycle + 1;
            if (w && a < 32'd4096) begin m_mem[a[11:0]] = d; m_ok[a[11:0]] = 1; end
            if (w && off == 0) m_leds = d[15:0];
            if (w && off == 2) m_fault = 0;
            else if (a >= 32'd4096 && off >= 16) begin
                if (w) m_fault[0] = 1; else m_fault[1] = 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clock) begin
        if (started) begin
            if (exp_ok) check("model_q", bus.q_dmem, exp_q);
            check("model_leds", {16'd0, leds}, {16'd0, m_leds});
            check("model_fault", {31'd0, fault}, {31'd0, (m_fault != 0)});
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
        @(negedge clock);
        #1;
        bus.address_dmem = a;
        bus.data         = d;
        bus.wren         = w;
    endtask

    task automatic expect_q(input string nm, input logic [31:0] v);
        @(posedge clock);
        #1;
        check(nm, bus.q_dmem, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.address_dmem = 32'd0;
        bus.data         = 32'd0;
        bus.wren         = 1'b0;
        repeat (2) @(negedge clock);
        #2;
        check("rst_q", bus.q_dmem, 32'd0);
        check("rst_leds", {16'd0, leds}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);

        @(negedge clock); #1;
        reset = 1'b1;
        bus.address_dmem = c_base + 5;
        expect_q("rsvd_after_rst", 32'd0);

        // RAM write then read, including the top word
        drive(32'd3, 32'hDEAD_BEEF, 1'b1);
        drive(32'd3, 32'd0, 1'b0);
        expect_q("ram3", 32'hDEAD_BEEF);
        drive(32'd4095, 32'h1, 1'b1);
        drive(32'd4095, 32'd0, 1'b0);
        expect_q("ram4095", 32'h1);
        drive(32'd0, 32'hA5, 1'b1);
        drive(32'd5, 32'h77, 1'b1);

        // LED register
        drive(c_base, 32'hABCD_1234, 1'b1);
        drive(c_base, 32'd0, 1'b0);
        expect_q("led_rd", 32'h0000_1234);
        check("led_out", {16'd0, leds}, 32'h0000_1234);

        // Cycle counter clear then count
        drive(c_base + 1, 32'd0, 1'b1);
        drive(c_base + 1, 32'd0, 1'b0);
        expect_q("cyc0", 32'd0);
        expect_q("cyc1", 32'd1);
        expect_q("cyc2", 32'd2);

        // Counter wrap from a preloaded value
        @(negedge clock); #1;
        force dut.r_cycle = 32'hFFFF_FFFE;
        #1;
        release dut.r_cycle;
        m_cycle = 32'hFFFF_FFFE;
        bus.address_dmem = c_base + 1;
        bus.wren = 1'b0;
        expect_q("cyc_fffe", 32'hFFFF_FFFE);
        expect_q("cyc_ffff", 32'hFFFF_FFFF);
        expect_q("cyc_wrap", 32'd0);

        // Out-of-range write, fault clear, out-of-range read
        drive(32'h0000_1000, 32'h0BAD, 1'b1);
        drive(c_base + 2, 32'd0, 1'b0);
        expect_q("flt_w", 32'h1);
        check("flt_w_out", {31'd0, fault}, 32'd1);
        drive(32'd0, 32'd0, 1'b0);
        expect_q("ram0_intact", 32'hA5);
        drive(c_base + 2, 32'hFFFF_FFFF, 1'b1);
        drive(c_base + 3, 32'hFFFF, 1'b1);
        drive(c_base + 3, 32'd0, 1'b0);
        expect_q("rsvd_rd", 32'd0);
        check("flt_clr_out", {31'd0, fault}, 32'd0);
        drive(32'h0000_2000, 32'd0, 1'b0);
        drive(c_base + 2, 32'd0, 1'b0);
        expect_q("flt_r", 32'h2);
        check("flt_r_out", {31'd0, fault}, 32'd1);

        // Writes while reset is held are dropped
        @(negedge clock); #1;
        reset = 1'b0;
        bus.address_dmem = 32'd5;
        bus.data = 32'h1234;
        bus.wren = 1'b1;
        repeat (2) @(negedge clock);
        #2;
        check("rst_mid_fault", {31'd0, fault}, 32'd0);
        check("rst_mid_leds", {16'd0, leds}, 32'd0);
        #1;
        reset = 1'b1;
        bus.wren = 1'b0;
        expect_q("rst_drop", 32'h77);

        // Read-during-write on RAM and LED
        drive(32'd7, 32'h11, 1'b1);
        drive(32'd7, 32'h55, 1'b1);
        expect_q("rdw_ram", c_fwd ? 32'h55 : 32'h11);
        drive(32'd7, 32'd0, 1'b0);
        expect_q("rdw_ram_after", 32'h55);
        drive(c_base, 32'h0000_4321, 1'b1);
        drive(c_base, 32'hFFFF_00AA, 1'b1);
        expect_q("rdw_led", c_fwd ? 32'h0000_00AA : 32'h0000_4321);

        drive(c_base + 5, 32'd0, 1'b0);
        @(negedge clock);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the processor's dmem interface (address_dmem / data / wren in, q_dmem out). It serves word-addressed synchronous RAM with 1-cycle read latency, plus a small memory-mapped I/O window: an LED register, a free-running cycle counter and a sticky fault register. It sits in the Wrapper beside imem and the RegFile. Its q_dmem is captured by the processor's MW latch.

Parameters:
ADDR_WIDTH, 12, word-address bits of RAM; depth = 2^ADDR_WIDTH words of 32 bits
MMIO_BASE, 32'hFFFF_0000, base word address of the MMIO window
LED_WIDTH, 16, width of the LED register

Ports:
clock  input  1  master clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
address_dmem  input  32  word address from the processor
data  input  32  write data from the processor
wren  input  1  write enable; 1 = write this cycle
q_dmem  output  32  registered read data
leds  output  LED_WIDTH  LED register contents
fault  output  1  OR of the fault register bits

Behaviour:
- Reset (reset=0, asynchronous): q_dmem=0, leds=0, cycle counter=0, fault register=0, fault=0. RAM contents are not cleared. Any write presented in a cycle where reset is low is dropped.
- Address decode happens every cycle on address_dmem:
  - RAM hit: address < 2^ADDR_WIDTH.
  - MMIO: MMIO_BASE+0 = LED (RW), +1 = CYCLE (RO value; a write clears it), +2 = FAULT (a read returns {30'b0, fault bits}; a write of any value clears it). MMIO_BASE+3 .. +15 are reserved.
  - Anything else is out-of-range.
- Read latency is exactly 1 cycle. On each edge, q_dmem <= the decoded read value of the address present before the edge. Reads happen every cycle regardless of wren.
- Read values:
  - LED reads return zero-extended leds.
  - CYCLE reads return the counter value before this edge's update.
  - Reserved and out-of-range reads return 0.
- Writes (wren=1) take effect on the edge.
  - RAM[address] <= data.
  - LED <= data[LED_WIDTH-1:0].
  - Writes to reserved addresses are ignored.
- Read-during-write to the same address returns the OLD data (read-before-write), unless the optional feature below is compiled in.
- Cycle counter: +1 every edge out of reset and wraps from 32'hFFFF_FFFF to 0. A write to CYCLE on the same edge forces it to 0; the clear wins over the increment.
- Fault register bits:
  - bit0: an out-of-range write was attempted. The write is ignored.
  - bit1: an out-of-range read occurred, qualified by wren=0 or not. Treat every cycle's address as a read, but set bit1 only when wren=0, so idle address buses do not fault.
  - Bits are sticky and are cleared only by reset or by a FAULT write.
  - A FAULT write clears the register on that edge. A new fault event on the same edge cannot occur, because the address is FAULT.
- fault output = |fault register, registered; it updates on the same edge as the register.
- No backpressure: the responder accepts one access every cycle with no stall.

Optional Feature:
DMEM_WRITE_FORWARD_EN
- Defined: a same-cycle read and write to the same RAM or LED address returns the NEW data (data input, masked to LED_WIDTH for LED) in q_dmem on the next edge.
- Undefined: the OLD contents are returned.
- CYCLE and FAULT behaviour is identical either way.

Test Plan:
- Reset release then address_dmem=0, wren=0 -> q_dmem=0, leds=0, fault=0. Hold reset low mid-run with wren=1 to addr 5, data=32'h1234 -> after release, a read of addr 5 returns its prior value.
- Write addr 3 = 32'hDEAD_BEEF, next cycle read addr 3 -> q_dmem=32'hDEAD_BEEF one edge after the address is presented. Read addr 4095 after writing 32'h1 -> 32'h1.
- Write MMIO_BASE+0 with 32'hABCD_1234 -> leds=16'h1234. Read back -> q_dmem=32'h0000_1234.
- Write MMIO_BASE+1, then read it on the next three cycles -> q_dmem=0, 1, 2. Preload the counter to near wrap by running 2^32 cycles or via force -> it wraps to 0.
- Write to 32'h0000_1000 (ADDR_WIDTH=12) -> no RAM change, fault=1, FAULT reads 32'h1. Write MMIO_BASE+2 -> fault=0. Read 32'h0000_2000 with wren=0 -> FAULT reads 32'h2.
- Same-cycle write of 32'h55 and read of addr 7 (previous value 32'h11) -> q_dmem=32'h11 without DMEM_WRITE_FORWARD_EN, 32'h55 with it.
